// File: rtl/direct_mapped_cache_ctrl_if.sv
// Bus bundle for the direct-mapped cache controller: CPU request/response
// channel plus the memory request and refill channel.
//   slave  : controller side (accepts CPU requests, issues memory requests)
//   master : environment side (CPU + memory)
interface direct_mapped_cache_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32
);
    logic              cpu_req_valid;
    logic              cpu_req_ready;
    logic              cpu_req_we;
    logic [ADDR_W-1:0] cpu_req_addr;
    logic [WORD_W-1:0] cpu_req_wdata;
    logic              cpu_resp_valid;
    logic [WORD_W-1:0] cpu_resp_rdata;
    logic              cpu_resp_hit;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [WORD_W-1:0] mem_req_wdata;
    logic              mem_rdata_valid;
    logic [WORD_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
        output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata, cpu_resp_hit,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        input  mem_req_ready, mem_rdata_valid, mem_rdata
    );

    modport master (
        output cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
        input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata, cpu_resp_hit,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        output mem_req_ready, mem_rdata_valid, mem_rdata
    );
endinterface

// File: rtl/direct_mapped_cache_ctrl.sv
// Direct-mapped, write-through / no-allocate cache controller with flush.
// Ports: clk, rst_n (sync, active low), bus (slave modport: CPU and memory
// channels), flush (invalidate-all pulse), hit_count / miss_count (saturating).
module direct_mapped_cache_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int WORD_W      = 32,
    parameter int BLOCK_WORDS = 16,
    parameter int NUM_BLOCKS  = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    direct_mapped_cache_ctrl_if.slave bus,
    input  logic        flush,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int OFF_W = $clog2(BLOCK_WORDS);
    localparam int IDX_W = $clog2(NUM_BLOCKS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, MISS_REQ, REFILL, WR_MEM, RESP
    } state_t;

    state_t r_state, w_next;

    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [WORD_W-1:0] r_wdata;
    logic              r_hit;
    logic [OFF_W-1:0]  r_beat;
    logic              r_flush_pend;
    logic [31:0]       r_hit_cnt;
    logic [31:0]       r_miss_cnt;

    logic [NUM_BLOCKS-1:0] r_valid;
    logic [TAG_W-1:0]      r_tag  [NUM_BLOCKS];
    logic [WORD_W-1:0]     r_data [NUM_BLOCKS*BLOCK_WORDS];

    logic              r_mem_valid, r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [WORD_W-1:0] r_mem_wdata;
    logic              r_resp_valid, r_resp_hit;
    logic [WORD_W-1:0] r_resp_rdata;

    logic [TAG_W-1:0]  w_tag;
    logic [IDX_W-1:0]  w_idx;
    logic [OFF_W-1:0]  w_off;
    logic [WORD_W-1:0] w_word;
    logic              w_hit, w_flush_any, w_ready, w_accept, w_last_beat;

    logic              w_mem_valid_d, w_mem_we_d;
    logic [ADDR_W-1:0] w_mem_addr_d;
    logic [WORD_W-1:0] w_mem_wdata_d;
    logic              w_resp_valid_d, w_resp_hit_d;
    logic [WORD_W-1:0] w_resp_rdata_d;

    assign w_tag       = r_addr[ADDR_W-1 -: TAG_W];
    assign w_idx       = r_addr[OFF_W +: IDX_W];
    assign w_off       = r_addr[OFF_W-1:0];
    assign w_word      = r_data[{w_idx, w_off}];
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_flush_any = flush | r_flush_pend;
    // A flush in IDLE (new or pending) always beats a new request.
    assign w_ready     = rst_n && (r_state == IDLE) && !w_flush_any;
    assign w_accept    = w_ready && bus.cpu_req_valid;
    assign w_last_beat = bus.mem_rdata_valid &&
                         (r_beat == OFF_W'(BLOCK_WORDS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:     if (w_accept) w_next = LOOKUP;
            LOOKUP:   w_next = r_we  ? WR_MEM :
                               w_hit ? RESP   : MISS_REQ;
            MISS_REQ: if (bus.mem_req_ready) w_next = REFILL;
            REFILL:   if (w_last_beat) w_next = RESP;
            WR_MEM:   if (bus.mem_req_ready) w_next = RESP;
            RESP:     w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // Next values for the registered outputs, keyed on the coming state.
    always_comb begin
        w_mem_valid_d  = (w_next == MISS_REQ) || (w_next == WR_MEM);
        w_mem_we_d     = (w_next == WR_MEM);
        w_mem_addr_d   = '0;
        w_mem_wdata_d  = '0;
        w_resp_valid_d = (w_next == RESP);
        w_resp_hit_d   = 1'b0;
        w_resp_rdata_d = '0;
        if (w_next == MISS_REQ)
            w_mem_addr_d = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        if (w_next == WR_MEM) begin
            w_mem_addr_d  = r_addr;
            w_mem_wdata_d = r_wdata;
        end
        if (w_next == RESP) begin
            unique case (r_state)
                LOOKUP: begin
                    w_resp_hit_d   = 1'b1;
                    w_resp_rdata_d = w_word;
                end
                // The last beat is not in the array yet; bypass it.
                REFILL:  w_resp_rdata_d = (w_off == r_beat) ?
                                          bus.mem_rdata : w_word;
                WR_MEM:  w_resp_hit_d = r_hit;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_hit        <= 1'b0;
            r_beat       <= '0;
            r_valid      <= '0;
            r_flush_pend <= 1'b0;
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
            r_mem_valid  <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_hit   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= bus.cpu_req_addr;
                r_we    <= bus.cpu_req_we;
                r_wdata <= bus.cpu_req_wdata;
            end
            if (r_state == LOOKUP) begin
                r_hit <= w_hit;
                if (w_hit) begin
                    if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 32'd1;
                end else begin
                    if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 32'd1;
                end
            end
            if (r_state == MISS_REQ)
                r_beat <= '0;
            else if (r_state == REFILL && bus.mem_rdata_valid)
                r_beat <= r_beat + 1'b1;
            if (r_state == IDLE) begin
                if (w_flush_any) begin
                    r_valid      <= '0;
                    r_flush_pend <= 1'b0;
                end
            end else if (flush) begin
                r_flush_pend <= 1'b1;
            end
            // Valid only after the whole line is in, so an aborted
            // refill leaves the line invalid.
            if (r_state == REFILL && w_last_beat)
                r_valid[w_idx] <= 1'b1;
            r_mem_valid  <= w_mem_valid_d;
            r_mem_we     <= w_mem_we_d;
            r_mem_addr   <= w_mem_addr_d;
            r_mem_wdata  <= w_mem_wdata_d;
            r_resp_valid <= w_resp_valid_d;
            r_resp_hit   <= w_resp_hit_d;
            r_resp_rdata <= w_resp_rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (r_state == LOOKUP && r_we && w_hit)
                r_data[{w_idx, w_off}] <= r_wdata;
            if (r_state == REFILL && bus.mem_rdata_valid)
                r_data[{w_idx, r_beat}] <= bus.mem_rdata;
            if (r_state == REFILL && w_last_beat)
                r_tag[w_idx] <= w_tag;
        end
    end

    assign bus.cpu_req_ready  = w_ready;
    assign bus.cpu_resp_valid = r_resp_valid;
    assign bus.cpu_resp_rdata = r_resp_rdata;
    assign bus.cpu_resp_hit   = r_resp_hit;
    assign bus.mem_req_valid  = r_mem_valid;
    assign bus.mem_req_we     = r_mem_we;
    assign bus.mem_req_addr   = r_mem_addr;
    assign bus.mem_req_wdata  = r_mem_wdata;
    assign hit_count          = r_hit_cnt;
    assign miss_count         = r_miss_cnt;
endmodule
